// File: rtl/ll_fifo_pkg.sv
// Shared sizing, types and round-robin helpers for the linked-list FIFO scheduler.
// The typedef widths follow the LL_* constants; instance parameters are expected to match them.
package ll_fifo_pkg;

  localparam int LL_WIDTH     = 8;
  localparam int LL_DEPTH     = 4;
  localparam int LL_NUM_FIFOS = 2;
  localparam int LL_SEL_WIDTH = (LL_NUM_FIFOS > 1) ? $clog2(LL_NUM_FIFOS) : 1;
  localparam int LL_CNT_WIDTH = $clog2(LL_DEPTH + 1);

  typedef logic [LL_SEL_WIDTH-1:0] sel_t;
  typedef logic [LL_CNT_WIDTH-1:0] cnt_t;
  typedef logic [LL_NUM_FIFOS-1:0] qmask_t;

  typedef struct packed {
    logic found;
    sel_t idx;
  } pick_t;

  localparam sel_t QUEUE_NONE = '0;

  // First set bit of mask at or above ptr, wrapping; idx is QUEUE_NONE when nothing is set.
  function automatic pick_t rr_pick(qmask_t mask, sel_t ptr);
    pick_t pick;
    int    k;
    pick = '{found: 1'b0, idx: QUEUE_NONE};
    for (int n = 0; n < LL_NUM_FIFOS; n++) begin
      k = (int'(ptr) + n) % LL_NUM_FIFOS;
      if (!pick.found && mask[k]) begin
        pick.found = 1'b1;
        pick.idx   = sel_t'(k);
      end
    end
    return pick;
  endfunction

  function automatic sel_t rr_next(sel_t idx);
    return (int'(idx) == LL_NUM_FIFOS - 1) ? QUEUE_NONE : sel_t'(int'(idx) + 1);
  endfunction

endpackage

// File: rtl/ll_fifo_sched_sva.sv
// Protocol checks on the scheduler-to-FIFO pins, bound into every ll_fifo_sched instance.
module ll_fifo_sched_sva
  import ll_fifo_pkg::*;
#(
  parameter int NUM_FIFOS = LL_NUM_FIFOS,
  parameter int SEL_WIDTH = LL_SEL_WIDTH,
  parameter int CNT_WIDTH = LL_CNT_WIDTH
) (
  input logic                           clk,
  input logic                           rst_n,
  input logic                           ll_push,
  input logic                           ll_pop,
  input logic                           ll_full,
  input logic [NUM_FIFOS-1:0]           ll_empty,
  input logic [SEL_WIDTH-1:0]           ll_pop_sel,
  input logic [NUM_FIFOS*CNT_WIDTH-1:0] occupancy
);

  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_queue
    a_cnt_matches_empty: assert property (@(posedge clk) disable iff (!rst_n)
      ((occupancy[i*CNT_WIDTH +: CNT_WIDTH] == '0) == ll_empty[i]));
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(ll_push && ll_full));

  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(ll_pop && ll_empty[ll_pop_sel]));

endmodule

bind ll_fifo_sched ll_fifo_sched_sva #(
  .NUM_FIFOS(NUM_FIFOS),
  .SEL_WIDTH(SEL_WIDTH),
  .CNT_WIDTH(CNT_WIDTH)
) u_sva (
  .clk       (clk),
  .rst_n     (rst_n),
  .ll_push   (ll_push),
  .ll_pop    (ll_pop),
  .ll_full   (ll_full),
  .ll_empty  (ll_empty),
  .ll_pop_sel(ll_pop_sel),
  .occupancy (occupancy)
);

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: request mask and priority pointer in, one-hot grant and index out.
module rr_arbiter
  import ll_fifo_pkg::*;
(
  input  logic [LL_NUM_FIFOS-1:0] req_i,
  input  logic [LL_SEL_WIDTH-1:0] ptr_i,
  output logic [LL_NUM_FIFOS-1:0] grant_o,
  output logic                    found_o,
  output logic [LL_SEL_WIDTH-1:0] idx_o
);

  pick_t pick;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick    = rr_pick(req_i, ptr_i);
    grant_o = '0;
    found_o = pick.found;
    idx_o   = pick.idx;
    if (pick.found) grant_o[pick.idx] = 1'b1;
  end

endmodule

// File: rtl/ll_fifo_sched.sv
// Round-robin push/pop scheduler in front of the shared linked-list FIFO, with per-queue
// occupancy quotas on the push side and a registered valid/ready stream on the pop side.
module ll_fifo_sched
  import ll_fifo_pkg::*;
#(
  parameter int WIDTH     = LL_WIDTH,
  parameter int DEPTH     = LL_DEPTH,
  parameter int NUM_FIFOS = LL_NUM_FIFOS,
  parameter int QUOTA     = DEPTH,
  parameter int SEL_WIDTH = LL_SEL_WIDTH,
  parameter int CNT_WIDTH = LL_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_FIFOS-1:0]           in_valid,
  input  logic [NUM_FIFOS*WIDTH-1:0]     in_data,
  output logic [NUM_FIFOS-1:0]           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [SEL_WIDTH-1:0]           out_sel,
  output logic                           ll_push,
  output logic                           ll_pop,
  output logic [SEL_WIDTH-1:0]           ll_push_sel,
  output logic [SEL_WIDTH-1:0]           ll_pop_sel,
  output logic [WIDTH-1:0]               ll_data_in,
  input  logic                           ll_full,
  input  logic [NUM_FIFOS-1:0]           ll_empty,
  input  logic [WIDTH-1:0]               ll_data_out,
  output logic [NUM_FIFOS*CNT_WIDTH-1:0] occupancy
);

  sel_t             push_ptr_q, push_ptr_d;
  sel_t             pop_ptr_q, pop_ptr_d;
  cnt_t             cnt_q [NUM_FIFOS];
  cnt_t             cnt_d [NUM_FIFOS];
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  sel_t             out_sel_q, out_sel_d;

  logic [NUM_FIFOS-1:0] push_req, pop_req, push_grant, pop_grant;
  logic                 push_found, pop_found, push_fire, pop_fire;
  sel_t                 push_idx, pop_idx;

  // ll_empty is the registered FIFO state, so a queue pushed this cycle cannot be popped this cycle.
  always_comb begin
    push_req = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      push_req[i] = in_valid[i] & ~ll_full & (cnt_q[i] < cnt_t'(QUOTA));
    end
    pop_req = (~out_valid_q | out_ready) ? ~ll_empty : '0;
  end

  rr_arbiter u_push_arb (
    .req_i  (push_req),
    .ptr_i  (push_ptr_q),
    .grant_o(push_grant),
    .found_o(push_found),
    .idx_o  (push_idx)
  );

  rr_arbiter u_pop_arb (
    .req_i  (pop_req),
    .ptr_i  (pop_ptr_q),
    .grant_o(pop_grant),
    .found_o(pop_found),
    .idx_o  (pop_idx)
  );

  // Gating with rst_n keeps every FIFO-facing strobe low while the FIFO itself is in reset.
  assign push_fire = rst_n & push_found;
  assign pop_fire  = rst_n & pop_found;

  always_comb begin
    in_ready    = push_fire ? push_grant : '0;
    ll_push     = push_fire;
    ll_push_sel = push_fire ? push_idx : QUEUE_NONE;
    ll_data_in  = push_fire ? in_data[int'(push_idx)*WIDTH +: WIDTH] : '0;
    ll_pop      = pop_fire;
    ll_pop_sel  = pop_fire ? pop_idx : QUEUE_NONE;
  end

  always_comb begin
    push_ptr_d  = push_fire ? rr_next(push_idx) : push_ptr_q;
    pop_ptr_d   = pop_fire ? rr_next(pop_idx) : pop_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (pop_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = ll_data_out;
      out_sel_d   = pop_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    for (int i = 0; i < NUM_FIFOS; i++) begin
      cnt_d[i] = cnt_q[i];
      case ({push_fire && (int'(push_idx) == i), pop_fire && (int'(pop_idx) == i)})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // NOTE: registers take their next value with non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_ptr_q  <= QUEUE_NONE;
      pop_ptr_q   <= QUEUE_NONE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= QUEUE_NONE;
      // NOTE: the counter array is control state that must track the FIFO, so each element is reset; bulk data storage normally would not be.
      for (int i = 0; i < NUM_FIFOS; i++) cnt_q[i] <= '0;
    end else begin
      push_ptr_q  <= push_ptr_d;
      pop_ptr_q   <= pop_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      for (int i = 0; i < NUM_FIFOS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NUM_FIFOS; i++) occupancy[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
  end

endmodule

// File: tb/tb_ll_fifo_sched.sv
// Bench for ll_fifo_sched: a behavioural shared FIFO as environment, and a queue-level
// reference model that predicts every scheduler output each cycle under random traffic.
module tb_ll_fifo_sched;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int NUM_FIFOS = 2;
  localparam int QUOTA     = 3;
  localparam int SEL_WIDTH = 1;
  localparam int CNT_WIDTH = 3;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic [NUM_FIFOS-1:0]           in_valid;
  logic [NUM_FIFOS*WIDTH-1:0]     in_data;
  logic [NUM_FIFOS-1:0]           in_ready;
  logic                           out_valid;
  logic                           out_ready;
  logic [WIDTH-1:0]               out_data;
  logic [SEL_WIDTH-1:0]           out_sel;
  logic                           ll_push, ll_pop;
  logic [SEL_WIDTH-1:0]           ll_push_sel, ll_pop_sel;
  logic [WIDTH-1:0]               ll_data_in;
  logic                           ll_full;
  logic [NUM_FIFOS-1:0]           ll_empty;
  logic [WIDTH-1:0]               ll_data_out;
  logic [NUM_FIFOS*CNT_WIDTH-1:0] occupancy;

  ll_fifo_sched #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_FIFOS(NUM_FIFOS), .QUOTA(QUOTA),
    .SEL_WIDTH(SEL_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
    .ll_push(ll_push), .ll_pop(ll_pop), .ll_push_sel(ll_push_sel), .ll_pop_sel(ll_pop_sel),
    .ll_data_in(ll_data_in), .ll_full(ll_full), .ll_empty(ll_empty),
    .ll_data_out(ll_data_out), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Shared FIFO environment: per-queue circular buffers, full when total reaches DEPTH.
  logic [WIDTH-1:0] env_mem [NUM_FIFOS][DEPTH];
  int               env_head [NUM_FIFOS];
  int               env_cnt  [NUM_FIFOS];

  always_comb begin
    int tot;
    tot = 0;
    ll_empty = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      ll_empty[i] = (env_cnt[i] == 0);
      tot += env_cnt[i];
    end
    ll_full = (tot == DEPTH);
  end

  assign ll_data_out = (env_cnt[ll_pop_sel] != 0) ? env_mem[ll_pop_sel][env_head[ll_pop_sel]] : '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FIFOS; i++) begin
        env_head[i] <= 0;
        env_cnt[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < NUM_FIFOS; i++) begin
        if (ll_push && !ll_full && int'(ll_push_sel) == i)
          env_mem[i][(env_head[i] + env_cnt[i]) % DEPTH] <= ll_data_in;
        if (ll_pop && env_cnt[i] != 0 && int'(ll_pop_sel) == i)
          env_head[i] <= (env_head[i] + 1) % DEPTH;
        env_cnt[i] <= env_cnt[i]
                    + ((ll_push && !ll_full && int'(ll_push_sel) == i) ? 1 : 0)
                    - ((ll_pop && env_cnt[i] != 0 && int'(ll_pop_sel) == i) ? 1 : 0);
      end
    end
  end

  // Reference model: what each logical queue holds, the two round-robin pointers, the output word.
  logic [WIDTH-1:0] mq [NUM_FIFOS][$];
  int               m_push_ptr, m_pop_ptr, m_os;
  logic             m_ov;
  logic [WIDTH-1:0] m_od;
  logic [WIDTH-1:0] stim [NUM_FIFOS];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  function automatic int rr_first(logic [NUM_FIFOS-1:0] elig, int ptr);
    for (int n = 0; n < NUM_FIFOS; n++)
      if (elig[(ptr + n) % NUM_FIFOS]) return (ptr + n) % NUM_FIFOS;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_FIFOS; i++) mq[i].delete();
    m_push_ptr = 0;
    m_pop_ptr  = 0;
    m_ov       = 1'b0;
    m_od       = '0;
    m_os       = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},    in_ready,    0);
    check({tag, "_ll_push"},     ll_push,     0);
    check({tag, "_ll_pop"},      ll_pop,      0);
    check({tag, "_ll_push_sel"}, ll_push_sel, 0);
    check({tag, "_ll_pop_sel"},  ll_pop_sel,  0);
    check({tag, "_ll_data_in"},  ll_data_in,  0);
    check({tag, "_out_valid"},   out_valid,   0);
    check({tag, "_out_data"},    out_data,    0);
    check({tag, "_out_sel"},     out_sel,     0);
    check({tag, "_occupancy"},   occupancy,   0);
  endtask

  // One clock: drive at the falling edge, compare against the model, advance the model at the rising edge.
  task automatic cycle(input logic [NUM_FIFOS-1:0] v, input logic rdy);
    int                   total, pw, pp;
    logic [NUM_FIFOS-1:0] pe, oe, exp_rdy;
    @(negedge clk);
    in_valid  = v;
    out_ready = rdy;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      stim[i] = WIDTH'($urandom);
      in_data[i*WIDTH +: WIDTH] = stim[i];
    end
    #1;
    total = 0;
    for (int i = 0; i < NUM_FIFOS; i++) total += mq[i].size();
    for (int i = 0; i < NUM_FIFOS; i++) begin
      pe[i] = v[i] && (total < DEPTH) && (mq[i].size() < QUOTA);
      oe[i] = (!m_ov || rdy) && (mq[i].size() != 0);
    end
    pw = rr_first(pe, m_push_ptr);
    pp = rr_first(oe, m_pop_ptr);
    exp_rdy = '0;
    if (pw >= 0) exp_rdy[pw] = 1'b1;

    check("in_ready", in_ready, exp_rdy);
    check("ll_push", ll_push, pw >= 0);
    if (pw >= 0) begin
      check("ll_push_sel", ll_push_sel, pw);
      check("ll_data_in", ll_data_in, stim[pw]);
    end
    check("ll_pop", ll_pop, pp >= 0);
    if (pp >= 0) check("ll_pop_sel", ll_pop_sel, pp);
    check("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check("out_data", out_data, m_od);
      check("out_sel", out_sel, m_os);
    end
    for (int i = 0; i < NUM_FIFOS; i++)
      check($sformatf("occupancy%0d", i), occupancy[i*CNT_WIDTH +: CNT_WIDTH], mq[i].size());

    @(posedge clk);
    if (pp >= 0) begin
      m_od      = mq[pp].pop_front();
      m_ov      = 1'b1;
      m_os      = pp;
      m_pop_ptr = (pp + 1) % NUM_FIFOS;
    end else if (rdy) begin
      m_ov = 1'b0;
    end
    if (pw >= 0) begin
      mq[pw].push_back(stim[pw]);
      m_push_ptr = (pw + 1) % NUM_FIFOS;
    end
  endtask

  initial begin
    int pct;
    rst_n     = 1'b0;
    in_valid  = '1;
    out_ready = 1'b0;
    in_data   = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters, stalled consumer: alternating grants until storage is full.
    repeat (8) cycle(2'b11, 1'b0);
    // Drain everything at one word per cycle.
    repeat (8) cycle(2'b00, 1'b1);
    // Requester 0 alone with a stalled consumer runs into its quota before storage is full.
    repeat (6) cycle(2'b01, 1'b0);

    // Reset in the middle of a cycle while a word is held on the output.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    in_valid  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with several consumer-readiness biases.
    for (int ph = 0; ph < 4; ph++) begin
      pct = (ph == 0) ? 15 : (ph == 1) ? 90 : (ph == 2) ? 50 : 70;
      repeat (150) cycle(NUM_FIFOS'($urandom_range(0, 3)), ($urandom_range(0, 99) < pct));
    end
    repeat (8) cycle(2'b00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
